trace_tx_scheduler: RTL and testbench
=====================================

Name: trace_tx_scheduler

Overview:
- Sequences one trace frame over the UART TX byte interface after each encryption.
- Frame order: 16 plaintext bytes, 16 key bytes, 16 ciphertext bytes, then NSAMPLES sensor samples read from the sample memory.
- After the frame, waits a fixed idle gap so the PDN can recover, then signals done.
- Sits between the main AES FSM (start/done handshake), the sensor sample RAM (read port) and uart_tx.

Parameters:
- NSAMPLES, 1024: number of sensor samples per frame.
- ADDR_W, 10: sample memory address width; NSAMPLES <= 2^ADDR_W.
- GAP_CYCLES, 4096: idle cycles after the last byte before done.
- GAP_W, 13: gap counter width; must hold GAP_CYCLES.

Ports:
- clk  in  1  system clock; same clock domain as uart_tx.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to send a frame; sampled only in IDLE.
- pt  in  128  plaintext; latched on accepted start.
- key  in  128  key; latched on accepted start.
- ct  in  128  ciphertext; latched on accepted start.
- smp_addr  out  ADDR_W  sample memory read address.
- smp_data  in  8  sample memory read data; valid 1 cycle after smp_addr.
- tx_dv  out  1  one-cycle byte strobe to uart_tx.
- tx_byte  out  8  byte to transmit; stable from the tx_dv cycle until tx_done.
- tx_done  in  1  uart_tx byte-complete pulse.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the frame and gap are complete.

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, tx_dv=0, tx_byte=0, smp_addr=0, busy=0, done=0. All counters and latched registers clear to 0.
- All outputs are registered.
- IDLE: when start=1, latch {pt,key,ct} into a 384-bit shift register, set busy=1, hdr_cnt=0, go to HDR_SEND. Otherwise remain in IDLE.
- HDR_SEND: tx_byte = shift_reg[383:376], i.e. MSB byte of pt first. tx_dv=1 for this one cycle. Go to HDR_WAIT.
- HDR_WAIT: tx_dv=0. On tx_done, shift the register left by 8 and increment hdr_cnt.
  - If hdr_cnt was 47, set smp_idx=0 and go to SMP_ADDR.
  - Otherwise go to HDR_SEND.
- SMP_ADDR: smp_addr=smp_idx. Go to SMP_READ.
- SMP_READ: capture smp_data into tx_byte, tx_dv=1. Go to SMP_WAIT.
- SMP_WAIT: tx_dv=0. On tx_done:
  - If smp_idx==NSAMPLES-1, go to GAP with gap_cnt=0.
  - Otherwise increment smp_idx and go to SMP_ADDR.
- GAP: increment gap_cnt. When gap_cnt==GAP_CYCLES-1, go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - start accepted at edge N → first tx_dv at edge N+1.
  - Header byte k+1 strobes 1 cycle after tx_done of byte k.
  - Sample bytes strobe 2 cycles after the previous tx_done.
- Timing constraint: tx_done asserted in the same cycle as tx_dv is not possible with uart_tx; the block does not need to handle it.
- Boundaries:
  - start while busy: ignored, no queuing.
  - tx_done outside HDR_WAIT/SMP_WAIT: ignored.
  - tx_done held high for more than one cycle: counts once per WAIT entry.
  - rst mid-frame: next cycle tx_dv=0 and busy=0, no further bytes, no done pulse.
  - NSAMPLES=1: exactly one sample byte is sent.
  - smp_idx never wraps past NSAMPLES-1.
- Total bytes per frame: 48+NSAMPLES, or 49+NSAMPLES with the optional feature enabled.

Optional Feature:
- Macro: TRACE_TX_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum, modulo 256, accumulates every byte on each tx_dv. It clears on accepted start.
  - After the last sample's tx_done, go to CSUM_SEND: tx_byte=sum, tx_dv=1.
  - Then CSUM_WAIT: on tx_done, go to GAP.
  - The checksum byte itself is not added to the sum.
- Undefined: no checksum logic; SMP_WAIT goes directly to GAP. Frame is 48+NSAMPLES bytes.

Test Plan:
- Header order: NSAMPLES=4, GAP_CYCLES=8, uart model asserts tx_done 10 cycles after tx_dv.
  - Stimulus: pt=0x000102…0F, key=0x101112…1F, ct=0x202122…2F, memory[i]=0xA0+i.
  - Required: bytes 0x00…0x2F, then 0xA0,0xA1,0xA2,0xA3; done exactly 8 cycles after the last tx_done plus FINISH; busy low with done.
- Read latency: memory returns the address value.
  - Required: every sample tx_byte equals the smp_addr driven the previous cycle; smp_addr never reaches 4.
- Start while busy: pulse start at byte 5.
  - Required: byte count still 52, single done, no second frame.
- Reset mid-frame: assert rst at sample byte 2 in SMP_WAIT.
  - Required: next cycle tx_dv=0, busy=0, done=0.
  - Then a new start gives a full, correct 52-byte frame.
- Stuck tx_done: tx_done held high for 3 cycles per byte.
  - Required: no skipped or duplicated bytes; total 52.
- With TRACE_TX_CHECKSUM_EN: pt=key=ct=all 0x01, samples all 0x02.
  - Required: 53rd byte = (48·1+4·2) mod 256 = 0x38.

Source files
------------

// File: rtl/trace_tx_scheduler_if.sv
// Trace transmit scheduler bus bundle.
// Groups the AES-FSM handshake, the sample-RAM read port and the uart_tx byte
// port. The master modport is the scheduler side; slave is the environment.
interface trace_tx_scheduler_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [127:0]      pt;
    logic [127:0]      key;
    logic [127:0]      ct;
    logic [ADDR_W-1:0] smp_addr;
    logic [7:0]        smp_data;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              busy;
    logic              done;

    modport master (
        input  start, pt, key, ct, smp_data, tx_done,
        output smp_addr, tx_dv, tx_byte, busy, done
    );

    modport slave (
        output start, pt, key, ct, smp_data, tx_done,
        input  smp_addr, tx_dv, tx_byte, busy, done
    );
endinterface

// File: rtl/trace_tx_scheduler.sv
// Trace transmit scheduler.
// After each encryption, sends one frame over uart_tx: 16 plaintext bytes,
// 16 key bytes, 16 ciphertext bytes, then NSAMPLES bytes from the sample RAM,
// then idles GAP_CYCLES cycles so the PDN settles, then pulses done.
// Optional feature macro: TRACE_TX_CHECKSUM_EN appends an 8-bit modulo-256
// sum of all frame bytes after the last sample.
module trace_tx_scheduler #(
    parameter int NSAMPLES   = 1024,
    parameter int ADDR_W     = 10,
    parameter int GAP_CYCLES = 4096,
    parameter int GAP_W      = 13
) (
    input logic                  clk,
    input logic                  rst,
    trace_tx_scheduler_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_SEND,
        S_HDR_WAIT,
        S_SMP_ADDR,
        S_SMP_READ,
        S_SMP_WAIT,
        S_CSUM_SEND,
        S_CSUM_WAIT,
        S_GAP,
        S_FINISH
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NSAMPLES - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [383:0]      shift_q, shift_d;
    logic [5:0]        hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_W-1:0] smp_idx_q, smp_idx_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tx_done_q;
    logic              tx_done_rise;
`ifdef TRACE_TX_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // A held-high tx_done must count only once, and the header path re-enters
    // HDR_WAIT one cycle after a byte completes, so only the rising edge counts.
    always_comb begin
        tx_done_rise = bus.tx_done & ~tx_done_q;
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves a latch behind.
        state_d    = state_q;
        shift_d    = shift_q;
        hdr_cnt_d  = hdr_cnt_q;
        smp_idx_d  = smp_idx_q;
        gap_cnt_d  = gap_cnt_q;
        smp_addr_d = smp_addr_q;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        tx_dv_d    = 1'b0;
        done_d     = 1'b0;
`ifdef TRACE_TX_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shift_d   = {bus.pt, bus.key, bus.ct};
                    hdr_cnt_d = 6'd0;
                    busy_d    = 1'b1;
`ifdef TRACE_TX_CHECKSUM_EN
                    sum_d     = 8'd0;
`endif
                    state_d   = S_HDR_SEND;
                end
            end
            S_HDR_SEND: begin
                tx_byte_d = shift_q[383:376];
                tx_dv_d   = 1'b1;
`ifdef TRACE_TX_CHECKSUM_EN
                sum_d     = sum_q + shift_q[383:376];
`endif
                state_d   = S_HDR_WAIT;
            end
            S_HDR_WAIT: begin
                if (tx_done_rise) begin
                    shift_d   = {shift_q[375:0], 8'h00};
                    hdr_cnt_d = hdr_cnt_q + 6'd1;
                    if (hdr_cnt_q == 6'd47) begin
                        // Address is registered on entry to SMP_ADDR so the
                        // RAM sees it for a full cycle before SMP_READ.
                        smp_idx_d  = '0;
                        smp_addr_d = '0;
                        state_d    = S_SMP_ADDR;
                    end else begin
                        state_d = S_HDR_SEND;
                    end
                end
            end
            S_SMP_ADDR: begin
                state_d = S_SMP_READ;
            end
            S_SMP_READ: begin
                tx_byte_d = bus.smp_data;
                tx_dv_d   = 1'b1;
`ifdef TRACE_TX_CHECKSUM_EN
                sum_d     = sum_q + bus.smp_data;
`endif
                state_d   = S_SMP_WAIT;
            end
            S_SMP_WAIT: begin
                if (tx_done_rise) begin
                    if (smp_idx_q == LAST_IDX) begin
`ifdef TRACE_TX_CHECKSUM_EN
                        state_d = S_CSUM_SEND;
`else
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
`endif
                    end else begin
                        smp_idx_d  = smp_idx_q + ADDR_W'(1);
                        smp_addr_d = smp_idx_q + ADDR_W'(1);
                        state_d    = S_SMP_ADDR;
                    end
                end
            end
`ifdef TRACE_TX_CHECKSUM_EN
            S_CSUM_SEND: begin
                // The checksum byte itself is not folded into the sum.
                tx_byte_d = sum_q;
                tx_dv_d   = 1'b1;
                state_d   = S_CSUM_WAIT;
            end
            S_CSUM_WAIT: begin
                if (tx_done_rise) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
`endif
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, latched frame data and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            hdr_cnt_q  <= '0;
            smp_idx_q  <= '0;
            gap_cnt_q  <= '0;
            smp_addr_q <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef TRACE_TX_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hdr_cnt_q  <= hdr_cnt_d;
            smp_idx_q  <= smp_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            smp_addr_q <= smp_addr_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_done_q  <= bus.tx_done;
`ifdef TRACE_TX_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.smp_addr = smp_addr_q;
    assign bus.tx_dv    = tx_dv_q;
    assign bus.tx_byte  = tx_byte_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_trace_tx_scheduler.sv
// Testbench for trace_tx_scheduler: scoreboard of expected frame bytes built
// from a frame-level model, a uart_tx responder, and a sample RAM model.
module tb_trace_tx_scheduler;

    localparam int NS    = 4;
    localparam int AW    = 3;
    localparam int GAP   = 8;
    localparam int GW    = 4;
`ifdef TRACE_TX_CHECKSUM_EN
    localparam int FRAME_LEN = 49 + NS;
`else
    localparam int FRAME_LEN = 48 + NS;
`endif
    localparam int LIMIT = 4000;

    logic clk;
    logic rst;

    trace_tx_scheduler_if #(.ADDR_W(AW)) bus ();

    trace_tx_scheduler #(
        .NSAMPLES  (NS),
        .ADDR_W    (AW),
        .GAP_CYCLES(GAP),
        .GAP_W     (GW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frame_bytes = 0;
    int done_cnt = 0;
    int last_txd_cyc = 0;
    int uart_delay = 10;
    int uart_hold = 1;
    int max_addr = 0;
    bit read_chk_en = 0;
    logic [7:0] last_byte = 8'h00;
    logic [AW-1:0] prev_addr = '0;
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous sample RAM: data valid the cycle after the address.
    always @(posedge clk) bus.smp_data <= mem[bus.smp_addr];

    // uart_tx responder: raises tx_done uart_delay cycles after each strobe,
    // holding it uart_hold cycles.
    initial begin
        int cd;
        int hc;
        cd = 0;
        hc = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cd = 0;
                hc = 0;
                bus.tx_done = 1'b0;
            end else begin
                if (hc > 0) begin
                    hc--;
                    if (hc == 0) bus.tx_done = 1'b0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.tx_done = 1'b1;
                        hc = uart_hold;
                        last_txd_cyc = cyc;
                    end
                end
                if (bus.tx_dv) cd = uart_delay;
            end
        end
    end

    // Monitor: pops the scoreboard on every strobe and checks done pulses.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.tx_dv) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_byte: got 0x%0h with no byte expected (cycle %0d)", bus.tx_byte, cyc);
                end else begin
                    check("tx_byte", bus.tx_byte, exp_q.pop_front());
                end
                if (read_chk_en && frame_bytes >= 48 && frame_bytes < 48 + NS)
                    check("smp_read_latency", bus.tx_byte, prev_addr);
                last_byte = bus.tx_byte;
                frame_bytes++;
            end
            if (bus.done) begin
                done_cnt++;
                check("busy_low_with_done", bus.busy, 0);
                check("done_timing", cyc, last_txd_cyc + GAP + 2);
                check("all_bytes_before_done", exp_q.size(), 0);
            end
            if (int'(bus.smp_addr) > max_addr) max_addr = int'(bus.smp_addr);
            prev_addr = bus.smp_addr;
        end
    end

    // Frame-level reference: header bytes MSB-first, samples in order, and
    // the optional modulo-256 sum of everything before it.
    function automatic void model_frame(input logic [127:0] p, input logic [127:0] k,
                                        input logic [127:0] c);
        logic [383:0] hdr;
        int sum;
        logic [7:0] b;
        hdr = {p, k, c};
        sum = 0;
        for (int i = 0; i < 48; i++) begin
            b = hdr[383 - 8*i -: 8];
            exp_q.push_back(b);
            sum += b;
        end
        for (int i = 0; i < NS; i++) begin
            exp_q.push_back(mem[i]);
            sum += mem[i];
        end
`ifdef TRACE_TX_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endfunction

    task automatic start_frame(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c);
        frame_bytes = 0;
        model_frame(p, k, c);
        @(negedge clk);
        bus.pt = p;
        bus.key = k;
        bus.ct = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // busy_start_at >= 0 pulses start (with new data) once that many bytes are out.
    task automatic finish_frame(input string name, input int busy_start_at);
        int d0;
        int n;
        bit fired;
        d0 = done_cnt - 0;
        d0 = done_cnt;
        n = 0;
        fired = 0;
        while (done_cnt == d0 && n < LIMIT) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (busy_start_at >= 0 && !fired && frame_bytes >= busy_start_at) begin
                bus.pt = {4{$urandom}};
                bus.start = 1'b1;
                fired = 1;
            end
        end
        bus.start = 1'b0;
        check({name, "_done_seen"}, done_cnt - d0, 1);
        check({name, "_frame_len"}, frame_bytes, FRAME_LEN);
        repeat (60) @(negedge clk);
        check({name, "_no_second_frame"}, frame_bytes, FRAME_LEN);
        check({name, "_single_done"}, done_cnt - d0, 1);
    endtask

    function automatic logic [127:0] ramp(input int base);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = 8'(base + i);
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.pt = '0;
        bus.key = '0;
        bus.ct = '0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = 8'hA0 + 8'(i);
        repeat (3) @(negedge clk);

        check("rst_tx_dv", bus.tx_dv, 0);
        check("rst_tx_byte", bus.tx_byte, 0);
        check("rst_smp_addr", bus.smp_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Header order with ramp data; samples 0xA0..0xA3.
        start_frame(ramp(0), ramp(16), ramp(32));
        check("busy_after_start", bus.busy, 1);
        finish_frame("hdr_order", -1);

        // Sample memory returns its own address.
        for (int i = 0; i < (1<<AW); i++) mem[i] = 8'(i);
        read_chk_en = 1;
        max_addr = 0;
        start_frame({4{$urandom}}, {4{$urandom}}, {4{$urandom}});
        finish_frame("read_latency", -1);
        check("smp_addr_max", max_addr, NS - 1);
        read_chk_en = 0;

        // Start while busy is ignored.
        for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);
        start_frame({4{$urandom}}, {4{$urandom}}, {4{$urandom}});
        finish_frame("start_busy", 5);

        // Reset in SMP_WAIT of sample byte 2.
        start_frame({4{$urandom}}, {4{$urandom}}, {4{$urandom}});
        n = 0;
        while (frame_bytes < 51 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("reach_sample2", frame_bytes, 51);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_dv", bus.tx_dv, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (40) @(negedge clk);
        check("midrst_no_bytes", frame_bytes, 51);
        check("midrst_no_done", done_cnt - d0, 0);
        start_frame(ramp(0), ramp(16), ramp(32));
        finish_frame("after_rst", -1);

        // tx_done held high for 3 cycles per byte.
        uart_hold = 3;
        start_frame({4{$urandom}}, {4{$urandom}}, {4{$urandom}});
        finish_frame("stuck_done", -1);
        uart_hold = 1;

        // All-0x01 header with 0x02 samples.
        for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h02;
        start_frame({16{8'h01}}, {16{8'h01}}, {16{8'h01}});
        finish_frame("ones_twos", -1);
`ifdef TRACE_TX_CHECKSUM_EN
        check("checksum_byte", last_byte, 8'h38);
`endif

        // Randomized frames with random uart timing.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);
            uart_delay = $urandom_range(4, 12);
            uart_hold = $urandom_range(1, 3);
            start_frame({4{$urandom}}, {4{$urandom}}, {4{$urandom}});
            finish_frame("random", -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
